// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared definitions for the gray_window3x3 neighbourhood stage.
//
//   Contents:
//     PIX_W_DEF      default gray pixel width (matches grayscale_converter)
//     WIN_N          number of elements in a 3x3 window
//     WIN_TL..WIN_BR flat element indices of the packed window, row-major,
//                    row 0 = oldest line, column 0 = leftmost column
//     win_idx(r,c)   flat element index of window position (r,c)
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_N     = 9;

    // Top row (oldest line)
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    // Middle row
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    // Bottom row (newest line)
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    // Flat element index of window position (r,c); element (r,c) occupies
    // bits [win_idx(r,c)*PIX_W +: PIX_W] of the packed window.
    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage : gray_pkg

// File: rtl/gray_line_buffer.sv
// -----------------------------------------------------------------------------
// gray_line_buffer
//   One image line of gray pixels. Single port, same-address
//   read-before-write: rdata always shows the value stored at addr before
//   any write performed on the coming clock edge, so a caller can fetch the
//   old pixel and overwrite it with the new one in the same cycle.
//
//   Parameters:
//     DEPTH   number of entries (pixels per line)
//     PIX_W   entry width in bits
//
//   Ports:
//     clk     in   clock, rising edge
//     we      in   write enable
//     addr    in   read/write address (column)
//     wdata   in   data written at addr when we=1
//     rdata   out  current (pre-write) contents at addr
// -----------------------------------------------------------------------------
module gray_line_buffer
    import gray_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         wdata,
    output logic [PIX_W-1:0]         rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Asynchronous read gives the old value in the same cycle as the write.
    assign rdata = mem[addr];

    // NOTE: the storage array has no reset; clearing it would need one write
    // per entry, and the caller never emits data from a line it has not yet
    // refilled this frame, so the power-up contents are harmless.
    always_ff @(posedge clk) begin
        // NOTE: registered state is always assigned with <= so every flop
        // samples its inputs from before the edge, independent of block order.
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule : gray_line_buffer

// File: rtl/gray_window3x3.sv
// -----------------------------------------------------------------------------
// gray_window3x3
//   Streaming 3x3 neighbourhood generator placed right after the grayscale
//   converter. Pixels arrive one per handshake in raster order; two line
//   buffers hold the previous two lines, and a 3x3 shift register forms the
//   window. A window is emitted for every fully interior position (no
//   border padding), one cycle after the pixel that completes it.
//
//   Parameters:
//     IMG_WIDTH   pixels per line, >= 3
//     IMG_HEIGHT  lines per frame, >= 3
//     PIX_W       bits per gray pixel
//
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   asynchronous active-high reset
//     pix_in      in   gray pixel
//     pix_valid   in   pix_in is valid
//     pix_sof     in   start of frame; the accepted pixel becomes (0,0)
//     pix_ready   out  a pixel can be accepted this cycle
//     win_out     out  packed window; element (r,c) at [(3*r+c)*PIX_W +: PIX_W],
//                      r=0 oldest line, c=0 leftmost column
//     win_valid   out  win_out holds a window
//     win_ready   in   consumer takes the window
//     frame_done  out  qualifies the last window of a frame
//
//   Optional feature (macro GRAY_WIN_COORD_EN):
//     win_x       out  window centre column (col-1), held with win_out
//     win_y       out  window centre row    (row-1), held with win_out
// -----------------------------------------------------------------------------
module gray_window3x3
    import gray_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
    output logic                   pix_ready,
    output logic [WIN_N*PIX_W-1:0] win_out,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   frame_done
`ifdef GRAY_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    // First column/row at which a full 3x3 neighbourhood is available.
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    // -------------------------------------------------------------------------
    // Position tracking
    // -------------------------------------------------------------------------
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;     // position of the pixel on pix_in
    logic [RW-1:0] cur_row;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic          col_last;
    logic          row_last;
    logic          accept;
    logic          emit;

    // One output slot: a pixel may enter only if the slot is empty or is
    // being drained this cycle, so the pipeline runs at full rate.
    assign pix_ready = win_ready || !win_valid;
    assign accept    = pix_valid && pix_ready;

    // Start of frame overrides the counters for the pixel that carries it.
    assign cur_col  = pix_sof ? '0 : col;
    assign cur_row  = pix_sof ? '0 : row;
    assign col_last = (cur_col == COL_LAST);
    assign row_last = (cur_row == ROW_LAST);

    // Windows never straddle a line wrap: column gating skips the two
    // positions whose left neighbours belong to the previous line, and row
    // gating skips lines whose buffers still hold the previous frame.
    assign emit = accept && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        col_nxt = cur_col + CW'(1);
        row_nxt = cur_row;
        if (col_last) begin
            col_nxt = '0;
            row_nxt = row_last ? '0 : cur_row + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers
    //   lb1 holds the previous line, lb0 the line before it. On each accept
    //   the new pixel goes into lb1 and the displaced lb1 pixel moves down
    //   into lb0, both at the current column.
    // -------------------------------------------------------------------------
    logic [PIX_W-1:0] lb0_rdata;
    logic [PIX_W-1:0] lb1_rdata;

    gray_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (lb1_rdata),
        .rdata (lb0_rdata)
    );

    gray_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (pix_in),
        .rdata (lb1_rdata)
    );

    // -------------------------------------------------------------------------
    // Window shift register
    //   Columns move left by one; the new right-hand column is
    //   {oldest line, previous line, incoming pixel}. The register itself is
    //   the output: while a window waits, pix_ready is low so no accept can
    //   disturb it.
    // -------------------------------------------------------------------------
    logic [WIN_N*PIX_W-1:0] win_q;
    logic [WIN_N*PIX_W-1:0] win_shift;

    always_comb begin
        win_shift = win_q;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_shift[win_idx(r, c)*PIX_W +: PIX_W] =
                    win_q[win_idx(r, c + 1)*PIX_W +: PIX_W];
            end
        end
        win_shift[WIN_TR*PIX_W +: PIX_W] = lb0_rdata;
        win_shift[WIN_MR*PIX_W +: PIX_W] = lb1_rdata;
        win_shift[WIN_BR*PIX_W +: PIX_W] = pix_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_shift;
        end
    end

    assign win_out = win_q;

    // -------------------------------------------------------------------------
    // Output qualifiers
    //   A new window always wins over the one being handed off, so the slot
    //   stays full with back-to-back windows. Otherwise the slot empties
    //   when the consumer takes it and holds when it does not.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (emit) begin
            win_valid  <= 1'b1;
            frame_done <= col_last && row_last;
        end else if (win_ready) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

`ifdef GRAY_WIN_COORD_EN
    // Centre coordinates are captured only with a new window, so they stay
    // aligned with win_out while it is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_x <= '0;
            win_y <= '0;
        end else if (emit) begin
            win_x <= cur_col - CW'(1);
            win_y <= cur_row - RW'(1);
        end
    end
`endif

endmodule : gray_window3x3
